// File: rtl/gray_frame_capture_pkg.sv
// Shared definitions for the gray frame capture path and the downstream
// window processor that reads the gray RAM.
package gray_frame_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_READY   = 2'd2
    } cap_state_t;

    localparam int unsigned IMG_W_DEF      = 240;
    localparam int unsigned IMG_H_DEF      = 130;
    localparam int unsigned GRAY_RAM_DEPTH = 32768;
    localparam int unsigned GRAY_ADDR_W    = 15;

    localparam logic [7:0] LUMA_R = 8'd77;
    localparam logic [7:0] LUMA_G = 8'd150;
    localparam logic [7:0] LUMA_B = 8'd29;

endpackage

// File: rtl/rgb565_to_gray.sv
// Two-stage RGB565 to 8-bit luma: weighted products registered, then the
// 16-bit sum is registered with the top byte taken as the gray value.
module rgb565_to_gray
    import gray_frame_capture_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_valid,
    input  logic [15:0] i_rgb565,
    output logic        o_valid,
    output logic [7:0]  o_gray
);

    logic [7:0]  w_r8;
    logic [7:0]  w_g8;
    logic [7:0]  w_b8;
    logic [15:0] w_sum;

    logic        r_v1;
    logic        r_v2;
    logic [15:0] r_pr;
    logic [15:0] r_pg;
    logic [15:0] r_pb;
    logic [7:0]  r_gray;

    // Replicating the channel MSBs into the low bits maps full scale to 255.
    assign w_r8  = {i_rgb565[15:11], i_rgb565[15:13]};
    assign w_g8  = {i_rgb565[10:5],  i_rgb565[10:9]};
    assign w_b8  = {i_rgb565[4:0],   i_rgb565[4:2]};
    assign w_sum = r_pr + r_pg + r_pb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_pr   <= '0;
            r_pg   <= '0;
            r_pb   <= '0;
            r_gray <= '0;
        end else begin
            r_v1 <= i_valid && !i_flush;
            r_v2 <= r_v1 && !i_flush;
            if (i_valid) begin
                r_pr <= {8'd0, LUMA_R} * {8'd0, w_r8};
                r_pg <= {8'd0, LUMA_G} * {8'd0, w_g8};
                r_pb <= {8'd0, LUMA_B} * {8'd0, w_b8};
            end
            if (r_v1) begin
                r_gray <= w_sum[15:8];
            end
        end
    end

    assign o_valid = r_v2;
    assign o_gray  = r_gray;

endmodule

// File: rtl/gray_frame_capture.sv
// Captures a window of each video frame as 8-bit gray into a RAM and holds
// the frame for the window processor until it signals proc_done.
module gray_frame_capture
    import gray_frame_capture_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF,
    parameter int unsigned X_OFF = 0,
    parameter int unsigned Y_OFF = 0
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        vs,
    input  logic        cv_de,
    input  logic [15:0] rgb565,
    input  logic        proc_done,
    output logic        wr_req,
    output logic [7:0]  gray_data_in,
    output logic [14:0] gray_data_addra,
    output logic        enable,
    output logic [7:0]  drop_cnt
);

    localparam logic [15:0] X_LO   = 16'(X_OFF);
    localparam logic [15:0] Y_LO   = 16'(Y_OFF);
    localparam logic [15:0] W16    = 16'(IMG_W);
    localparam logic [15:0] H16    = 16'(IMG_H);
    localparam logic [15:0] LAST   = 16'(IMG_W * IMG_H - 1);
    localparam logic [14:0] LAST_A = 15'(IMG_W * IMG_H - 1);

    generate
        if (IMG_W * IMG_H > GRAY_RAM_DEPTH) begin : g_size_check
            $error("gray_frame_capture: IMG_W*IMG_H exceeds gray RAM depth");
        end
    endgenerate

    cap_state_t  r_state;
    logic        r_vs_d;
    logic        r_de_d;
    logic [15:0] r_x_cnt;
    logic [15:0] r_y_cnt;
    logic [15:0] r_addr;
    logic [14:0] r_addr_p1;
    logic [14:0] r_addr_p2;
    logic        r_cap_d;
    logic [7:0]  r_drop;

    logic        w_vs_rise;
    logic        w_de_fall;
    logic [15:0] w_xrel;
    logic [15:0] w_yrel;
    logic        w_cap;
    logic        w_gray_valid;
    logic [7:0]  w_gray;

    assign w_vs_rise = vs && !r_vs_d;
    assign w_de_fall = r_de_d && !cv_de;
    // Offset-relative counts wrap below the offset, so one compare bounds both ends.
    assign w_xrel    = r_x_cnt - X_LO;
    assign w_yrel    = r_y_cnt - Y_LO;
    assign w_cap     = (r_state == ST_CAPTURE) && !w_vs_rise && cv_de &&
                       (w_xrel < W16) && (w_yrel < H16) && (r_addr <= LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_d  <= vs;
            r_de_d  <= cv_de;
            r_x_cnt <= '0;
            r_y_cnt <= '0;
        end else begin
            r_vs_d <= vs;
            r_de_d <= cv_de;
            if (w_de_fall) begin
                r_x_cnt <= '0;
            end else if (cv_de) begin
                r_x_cnt <= r_x_cnt + 16'd1;
            end
            if (w_vs_rise) begin
                r_y_cnt <= '0;
            end else if (w_de_fall) begin
                r_y_cnt <= r_y_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_drop  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_vs_rise) begin
                        r_state <= ST_CAPTURE;
                        r_addr  <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (w_vs_rise) begin
                        r_addr <= '0;
                        if (r_drop != '1) r_drop <= r_drop + 8'd1;
                    end else begin
                        if (w_cap) r_addr <= r_addr + 16'd1;
                        if (wr_req && (gray_data_addra == LAST_A)) r_state <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (w_vs_rise && (r_drop != '1)) r_drop <= r_drop + 8'd1;
                    if (proc_done) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Address travels alongside the gray pipeline so the write is aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_d   <= 1'b0;
            r_addr_p1 <= '0;
            r_addr_p2 <= '0;
        end else begin
            r_cap_d <= w_cap;
            if (w_cap)   r_addr_p1 <= r_addr[14:0];
            if (r_cap_d) r_addr_p2 <= r_addr_p1;
        end
    end

    rgb565_to_gray u_gray (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (w_vs_rise && (r_state == ST_CAPTURE)),
        .i_valid  (w_cap),
        .i_rgb565 (rgb565),
        .o_valid  (w_gray_valid),
        .o_gray   (w_gray)
    );

    assign wr_req          = w_gray_valid;
    assign gray_data_in    = w_gray;
    assign gray_data_addra = r_addr_p2;
    assign enable          = (r_state == ST_READY);
    assign drop_cnt        = r_drop;

endmodule

// File: tb/tb_gray_frame_capture.sv
// Scoreboard bench for gray_frame_capture on a reduced window with offsets;
// the driver's frame model predicts writes and enable edges, a monitor checks.
module tb_gray_frame_capture;

    localparam int W      = 16;
    localparam int H      = 8;
    localparam int XO     = 3;
    localparam int YO     = 2;
    localparam int LINE   = 24;
    localparam int NLINES = 12;
    localparam int HBL    = 4;

    typedef struct {
        int addr;
        int gray;
        int cyc;
    } wr_t;

    typedef struct {
        int cyc;
        bit val;
    } en_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vs;
    logic        cv_de;
    logic [15:0] rgb565;
    logic        proc_done;
    logic        wr_req;
    logic [7:0]  gray_data_in;
    logic [14:0] gray_data_addra;
    logic        enable;
    logic [7:0]  drop_cnt;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];
    en_t en_q[$];
    bit  exp_en = 1'b0;

    // Frame model: 0 waiting for frame start, 1 capturing, 2 frame held.
    int  m_state;
    int  m_addr;
    int  m_drop;
    bit  red_origin;

    gray_frame_capture #(
        .IMG_W (W),
        .IMG_H (H),
        .X_OFF (XO),
        .Y_OFF (YO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .vs              (vs),
        .cv_de           (cv_de),
        .rgb565          (rgb565),
        .proc_done       (proc_done),
        .wr_req          (wr_req),
        .gray_data_in    (gray_data_in),
        .gray_data_addra (gray_data_addra),
        .enable          (enable),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ref_gray(input int p);
        int r, g, b;
        r = (p / 2048) % 32;
        g = (p / 32) % 64;
        b = p % 32;
        r = r * 8 + r / 4;
        g = g * 4 + g / 16;
        b = b * 8 + b / 4;
        return (77 * r + 150 * g + 29 * b) / 256;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_write addr=%0d due_cycle=%0d actual=none required=write", e.addr, e.cyc);
        end
        if (wr_req === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write cycle=%0d actual_addr=%0d actual_gray=%0d required=no write",
                         cyc, gray_data_addra, gray_data_in);
            end else begin
                e = exp_q.pop_front();
                if (int'(gray_data_addra) != e.addr || int'(gray_data_in) != e.gray || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL write actual addr=%0d gray=%0d cycle=%0d required addr=%0d gray=%0d cycle=%0d",
                             gray_data_addra, gray_data_in, cyc, e.addr, e.gray, e.cyc);
                end
            end
        end
        while (en_q.size() > 0 && en_q[0].cyc <= cyc) begin
            exp_en = en_q[0].val;
            void'(en_q.pop_front());
        end
        checks++;
        if (enable !== exp_en) begin
            errors++;
            $display("FAIL enable cycle=%0d actual=%0b required=%0b", cyc, enable, exp_en);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_vs();
        if (m_state == 0) begin
            m_state = 1;
            m_addr  = 0;
        end else begin
            if (m_drop < 255) m_drop++;
            if (m_state == 1) m_addr = 0;
        end
    endtask

    task automatic drive_pixel(input int x, input int y, input int pix);
        cv_de  = 1'b1;
        rgb565 = pix[15:0];
        if (m_state == 1 && x >= XO && x < XO + W && y >= YO && y < YO + H) begin
            exp_q.push_back('{m_addr, ref_gray(pix), cyc + 2});
            if (m_addr == W * H - 1) begin
                m_state = 2;
                en_q.push_back('{cyc + 3, 1'b1});
            end
            m_addr++;
        end
        step();
    endtask

    task automatic drive_frame(input int y0, input int nlines, input int npix, input int mode);
        int pix;
        for (int y = y0; y < y0 + nlines; y++) begin
            for (int x = 0; x < npix; x++) begin
                case (mode)
                    1:       pix = x * 256 + y;
                    2:       pix = 16'hFFFF;
                    default: pix = int'($urandom_range(0, 65535));
                endcase
                if (red_origin && x == XO && y == YO) pix = 16'hF800;
                drive_pixel(x, y, pix);
            end
            cv_de = 1'b0;
            repeat (HBL) step();
        end
    endtask

    task automatic vs_pulse();
        vs = 1'b1;
        model_vs();
        step();
        step();
        vs = 1'b0;
        repeat (3) step();
    endtask

    task automatic proc_done_pulse();
        proc_done = 1'b1;
        if (m_state == 2) begin
            m_state = 0;
            en_q.push_back('{cyc + 1, 1'b0});
        end
        step();
        proc_done = 1'b0;
        step();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        if (m_state == 2) en_q.push_back('{cyc + 1, 1'b0});
        m_state = 0;
        m_addr  = 0;
        m_drop  = 0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; vs = 1'b0; cv_de = 1'b0; rgb565 = '0; proc_done = 1'b0;
        m_state = 0; m_addr = 0; m_drop = 0; red_origin = 1'b0;
        repeat (3) step();
        chk("reset_wr_req", int'(wr_req), 0);
        chk("reset_enable", int'(enable), 0);
        chk("reset_gray", int'(gray_data_in), 0);
        chk("reset_addr", int'(gray_data_addra), 0);
        chk("reset_drop", int'(drop_cnt), 0);
        rst = 1'b0;
        step();

        // Video before any frame start must not be captured.
        drive_frame(0, 4, LINE, 0);

        // Pure red at the window origin; proc_done during capture is ignored.
        vs_pulse();
        red_origin = 1'b1;
        drive_frame(0, 3, LINE, 0);
        red_origin = 1'b0;
        proc_done_pulse();
        drive_frame(3, NLINES - 3, LINE, 0);
        repeat (4) step();
        chk("enable_after_frame", int'(enable), 1);

        // Three frames arrive while the buffer is held.
        for (int i = 0; i < 3; i++) begin
            vs_pulse();
            drive_frame(0, NLINES, LINE, 0);
        end
        chk("drop_held_frames", int'(drop_cnt), m_drop);
        chk("drop_is_three", int'(drop_cnt), 3);
        proc_done_pulse();
        chk("enable_released", int'(enable), 0);
        proc_done_pulse();

        vs_pulse();
        drive_frame(0, NLINES, LINE, 1);
        proc_done_pulse();
        vs_pulse();
        drive_frame(0, NLINES, LINE, 2);
        proc_done_pulse();

        // Restart part-way through a frame.
        vs_pulse();
        drive_frame(0, 5, LINE, 0);
        vs_pulse();
        chk("drop_restart", int'(drop_cnt), 4);
        drive_frame(0, NLINES, LINE, 0);
        proc_done_pulse();

        // Short lines never reach the last address.
        vs_pulse();
        drive_frame(0, NLINES, 12, 0);
        repeat (5) step();
        chk("enable_short_lines", int'(enable), 0);
        vs_pulse();
        chk("drop_short_lines", int'(drop_cnt), 5);
        drive_frame(0, NLINES, LINE, 0);
        proc_done_pulse();

        // Reset mid-capture, then video without a frame start.
        vs_pulse();
        drive_frame(0, 4, LINE, 0);
        reset_pulse();
        chk("drop_after_reset", int'(drop_cnt), 0);
        drive_frame(4, NLINES - 4, LINE, 0);
        vs_pulse();
        drive_frame(0, NLINES, LINE, 0);
        reset_pulse();
        chk("enable_after_reset", int'(enable), 0);

        // Saturate the drop counter while a frame is held.
        vs_pulse();
        drive_frame(0, NLINES, LINE, 0);
        for (int i = 0; i < 260; i++) vs_pulse();
        chk("drop_saturated", int'(drop_cnt), 255);
        proc_done_pulse();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
